// File: rtl/core_s2_lsu_seq_if.sv
// Data-cache request/response bus between the stage-2 load/store sequencer and the dcache.
// master: LSU side. It drives the request and receives ready and the response.
// slave : dcache side.
interface core_s2_lsu_seq_if;
  logic        dcache_req_valid;
  logic        dcache_req_ready;
  logic [31:0] dcache_addr;
  logic        dcache_we;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_wmask;
  logic        dcache_rsp_valid;
  logic [31:0] dcache_rdata;

  modport master (
    output dcache_req_valid, dcache_addr, dcache_we, dcache_wdata, dcache_wmask,
    input  dcache_req_ready, dcache_rsp_valid, dcache_rdata
  );

  modport slave (
    input  dcache_req_valid, dcache_addr, dcache_we, dcache_wdata, dcache_wmask,
    output dcache_req_ready, dcache_rsp_valid, dcache_rdata
  );
endinterface

// File: rtl/core_s2_lsu_seq.sv
// Stage-2 load/store sequencer.
// It accepts one aligned access from the pipeline and issues it on the dcache bus.
// For a load it waits up to RSP_TIMEOUT cycles for the response.
// It writes the formatted load result back for one cycle in DONE.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mem_*               stage-2 access: request, store flag, size, sign, address, store data
//   rd_idx, flush       load destination register; kill of the stage-2 instruction
//   dcache (master)     dcache request and response bus
//   s2_stall            holds stage 2 while the access is outstanding
//   ld_we/ld_rd_idx/ld_wd  register-file write port for the load result
//   misaligned, bus_err    single-cycle exception pulses
module core_s2_lsu_seq #(
  parameter int unsigned RSP_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_req,
  input  logic                     mem_we,
  input  logic [1:0]               mem_size,
  input  logic                     mem_signed,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wd,
  input  logic [4:0]               rd_idx,
  input  logic                     flush,
  core_s2_lsu_seq_if.master        dcache,
  output logic                     s2_stall,
  output logic                     ld_we,
  output logic [4:0]               ld_rd_idx,
  output logic [31:0]              ld_wd,
  output logic                     misaligned,
  output logic                     bus_err
);

  localparam int unsigned CNT_W = (RSP_TIMEOUT < 1) ? 1 : $clog2(RSP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic              we_q, sgn_q, killed_q, err_q;
  logic [1:0]        size_q;
  logic [4:0]        rd_q;
  logic [3:0]        wmask_q;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;

  logic              mis, accept, cnt_clr, cnt_inc, rsp_cap, to_err, kill_set;
  logic              stall_c, mis_c;
  logic [3:0]        wmask_n;
  logic [31:0]       wdata_n, rsh;

  // Alignment check, byte-lane mask and lane-replicated store data for the incoming access.
  always_comb begin
    mis = (mem_size == 2'd3) ||
          (mem_size == 2'd1 && mem_addr[0]) ||
          (mem_size == 2'd2 && mem_addr[1:0] != 2'b00);
    wmask_n = 4'b1111;
    wdata_n = mem_wd;
    case (mem_size)
      2'd0: begin
        wmask_n = 4'b0001 << mem_addr[1:0];
        wdata_n = {4{mem_wd[7:0]}};
      end
      2'd1: begin
        wmask_n = 4'b0011 << mem_addr[1:0];
        wdata_n = {2{mem_wd[15:0]}};
      end
      default: ;
    endcase
  end

  assign cnt_nxt = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    rsp_cap  = 1'b0;
    to_err   = 1'b0;
    kill_set = 1'b0;
    stall_c  = 1'b0;
    mis_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req && !flush) begin
          if (mis) begin
            mis_c = 1'b1;
          end else begin
            accept  = 1'b1;
            stall_c = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall_c  = 1'b1;
        kill_set = flush;
        if (dcache.dcache_req_ready) begin
          cnt_clr = 1'b1;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        stall_c  = 1'b1;
        kill_set = flush;
        if (dcache.dcache_rsp_valid) begin
          rsp_cap = 1'b1;
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
          if (cnt_nxt == CNT_W'(RSP_TIMEOUT)) begin
            to_err  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        kill_set = flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The IDLE-state outputs are combinational from mem_req. They are gated so that
  // every output reads 0 while reset is held.
  assign s2_stall   = stall_c & rst_n;
  assign misaligned = mis_c & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      rd_q     <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      killed_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= mem_addr;
        we_q     <= mem_we;
        size_q   <= mem_size;
        sgn_q    <= mem_signed;
        rd_q     <= rd_idx;
        wdata_q  <= mem_we ? wdata_n : '0;
        wmask_q  <= mem_we ? wmask_n : '0;
        killed_q <= 1'b0;
        err_q    <= 1'b0;
      end
      if (kill_set) killed_q <= 1'b1;
      if (cnt_clr)       cnt_q <= '0;
      else if (cnt_inc)  cnt_q <= cnt_nxt;
      if (rsp_cap) rdata_q <= dcache.dcache_rdata;
      if (to_err)  err_q   <= 1'b1;
    end
  end

  assign dcache.dcache_req_valid = (state_q == REQ);
  assign dcache.dcache_addr      = addr_q;
  assign dcache.dcache_we        = we_q;
  assign dcache.dcache_wdata     = wdata_q;
  assign dcache.dcache_wmask     = wmask_q;

  // Load formatting. The addressed byte or half is moved down to bit 0, then extended.
  assign rsh = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    ld_wd = rsh;
    case (size_q)
      2'd0: ld_wd = {{24{sgn_q & rsh[7]}}, rsh[7:0]};
      2'd1: ld_wd = {{16{sgn_q & rsh[15]}}, rsh[15:0]};
      default: ;
    endcase
  end

  // A flush that arrives in the DONE cycle itself must also block the write.
  assign ld_we     = (state_q == DONE) && !we_q && !killed_q && !flush && !err_q && (rd_q != '0);
  assign ld_rd_idx = rd_q;
  assign bus_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_core_s2_lsu_seq.sv
module tb_core_s2_lsu_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_signed, flush;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wd;
  logic [4:0]  rd_idx;
  logic        s2_stall, ld_we, misaligned, bus_err;
  logic [4:0]  ld_rd_idx;
  logic [31:0] ld_wd;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned stall_cyc;

  core_s2_lsu_seq_if dif ();

  core_s2_lsu_seq #(.RSP_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .rd_idx     (rd_idx),
    .flush      (flush),
    .dcache     (dif),
    .s2_stall   (s2_stall),
    .ld_we      (ld_we),
    .ld_rd_idx  (ld_rd_idx),
    .ld_wd      (ld_wd),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock. Inputs are changed after the edge and outputs are sampled later, between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd3; mem_signed = 1'b0;
    mem_addr = 32'h0; mem_wd = 32'h0; rd_idx = 5'd0; flush = 1'b0;
    dif.dcache_req_ready = 1'b0; dif.dcache_rsp_valid = 1'b0; dif.dcache_rdata = 32'h0;
    #12;
    chk("rst_stall", 32'(s2_stall), 32'd0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_valid", 32'(dif.dcache_req_valid), 32'd0);
    chk("rst_addr", dif.dcache_addr, 32'h0);
    chk("rst_wmask", 32'(dif.dcache_wmask), 32'h0);
    chk("rst_ldwe", 32'(ld_we), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    mem_req = 1'b0; mem_size = 2'd0;
    rst_n = 1'b1;
    tick();

    // Signed byte load lb 0x1003, ready immediately, response two cycles after the handshake.
    stall_cyc = 0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_signed = 1'b1;
    mem_addr = 32'h0000_1003; rd_idx = 5'd5; dif.dcache_req_ready = 1'b1;
    settle();
    chk("lb_idle_stall", 32'(s2_stall), 32'd1);
    chk("lb_idle_valid", 32'(dif.dcache_req_valid), 32'd0);
    if (s2_stall) stall_cyc++;
    tick(); mem_req = 1'b0; mem_addr = 32'h0; settle();
    chk("lb_req_valid", 32'(dif.dcache_req_valid), 32'd1);
    chk("lb_req_addr", dif.dcache_addr, 32'h0000_1003);
    chk("lb_req_we", 32'(dif.dcache_we), 32'd0);
    if (s2_stall) stall_cyc++;
    tick(); dif.dcache_req_ready = 1'b0; settle();
    chk("lb_wait_valid", 32'(dif.dcache_req_valid), 32'd0);
    if (s2_stall) stall_cyc++;
    tick(); dif.dcache_rsp_valid = 1'b1; dif.dcache_rdata = 32'h80FF_FFFF; settle();
    if (s2_stall) stall_cyc++;
    tick(); dif.dcache_rsp_valid = 1'b0; dif.dcache_rdata = 32'h0; settle();
    chk("lb_done_ldwe", 32'(ld_we), 32'd1);
    chk("lb_done_ldwd", ld_wd, 32'hFFFF_FF80);
    chk("lb_done_rd", 32'(ld_rd_idx), 32'd5);
    chk("lb_done_stall", 32'(s2_stall), 32'd0);
    chk("lb_stall_cycles", stall_cyc, 32'd4);
    tick();
    chk("lb_idle_ldwe", 32'(ld_we), 32'd0);

    // Half store sh 0x2002 with ready held low for three REQ cycles.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1; mem_signed = 1'b0;
    mem_addr = 32'h0000_2002; mem_wd = 32'h1234_ABCD; rd_idx = 5'd0;
    settle();
    chk("sh_idle_stall", 32'(s2_stall), 32'd1);
    tick(); mem_req = 1'b0; mem_addr = 32'h0; mem_wd = 32'h0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("sh_hold_valid", 32'(dif.dcache_req_valid), 32'd1);
      chk("sh_hold_addr", dif.dcache_addr, 32'h0000_2002);
      chk("sh_hold_we", 32'(dif.dcache_we), 32'd1);
      chk("sh_hold_wdata", dif.dcache_wdata, 32'hABCD_ABCD);
      chk("sh_hold_wmask", 32'(dif.dcache_wmask), 32'hC);
      chk("sh_hold_stall", 32'(s2_stall), 32'd1);
      tick();
    end
    dif.dcache_req_ready = 1'b1; settle();
    chk("sh_hs_valid", 32'(dif.dcache_req_valid), 32'd1);
    tick(); dif.dcache_req_ready = 1'b0; settle();
    chk("sh_done_valid", 32'(dif.dcache_req_valid), 32'd0);
    chk("sh_done_stall", 32'(s2_stall), 32'd0);
    chk("sh_done_ldwe", 32'(ld_we), 32'd0);
    tick();

    // Misaligned lw 0x3001, and further alignment boundaries checked without clocking.
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_3001; rd_idx = 5'd6;
    settle();
    chk("mis_pulse", 32'(misaligned), 32'd1);
    chk("mis_stall", 32'(s2_stall), 32'd0);
    chk("mis_valid", 32'(dif.dcache_req_valid), 32'd0);
    mem_size = 2'd3; mem_addr = 32'h0000_3000; settle();
    chk("mis_size3", 32'(misaligned), 32'd1);
    mem_size = 2'd1; mem_addr = 32'h0000_3003; settle();
    chk("mis_half_odd", 32'(misaligned), 32'd1);
    mem_size = 2'd1; mem_addr = 32'h0000_3002; settle();
    chk("al_half_even", 32'(misaligned), 32'd0);
    chk("al_half_stall", 32'(s2_stall), 32'd1);
    flush = 1'b1; settle();
    chk("flush_idle_stall", 32'(s2_stall), 32'd0);
    mem_size = 2'd2; mem_addr = 32'h0000_3001; tick();
    flush = 1'b0; mem_req = 1'b0; settle();
    chk("mis_after_mis", 32'(misaligned), 32'd0);
    chk("mis_after_valid", 32'(dif.dcache_req_valid), 32'd0);
    chk("mis_after_stall", 32'(s2_stall), 32'd0);

    // Timeout with RSP_TIMEOUT=4: four WAIT cycles, then DONE with bus_err.
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h0000_4000; rd_idx = 5'd7;
    dif.dcache_req_ready = 1'b1;
    tick(); mem_req = 1'b0;
    tick(); dif.dcache_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("to_wait_stall", 32'(s2_stall), 32'd1);
      chk("to_wait_buserr", 32'(bus_err), 32'd0);
      tick();
    end
    settle();
    chk("to_done_buserr", 32'(bus_err), 32'd1);
    chk("to_done_ldwe", 32'(ld_we), 32'd0);
    chk("to_done_stall", 32'(s2_stall), 32'd0);
    tick();
    chk("to_idle_buserr", 32'(bus_err), 32'd0);

    // Flush in REQ: valid is not retracted, response consumed, no write.
    mem_req = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_5000; rd_idx = 5'd9;
    tick(); mem_req = 1'b0; flush = 1'b1; settle();
    chk("fl_req_valid", 32'(dif.dcache_req_valid), 32'd1);
    tick(); flush = 1'b0; settle();
    chk("fl_req_valid2", 32'(dif.dcache_req_valid), 32'd1);
    dif.dcache_req_ready = 1'b1;
    tick(); dif.dcache_req_ready = 1'b0;
    dif.dcache_rsp_valid = 1'b1; dif.dcache_rdata = 32'h1122_3344; settle();
    chk("fl_wait_stall", 32'(s2_stall), 32'd1);
    tick(); dif.dcache_rsp_valid = 1'b0; settle();
    chk("fl_done_ldwe", 32'(ld_we), 32'd0);
    chk("fl_done_stall", 32'(s2_stall), 32'd0);
    tick();

    // Load to x0: DONE is reached, data is formatted, but no write.
    mem_req = 1'b1; mem_size = 2'd2; mem_signed = 1'b0; mem_addr = 32'h0000_6004; rd_idx = 5'd0;
    dif.dcache_req_ready = 1'b1;
    tick(); mem_req = 1'b0;
    tick(); dif.dcache_req_ready = 1'b0; dif.dcache_rsp_valid = 1'b1; dif.dcache_rdata = 32'hDEAD_BEEF;
    tick(); dif.dcache_rsp_valid = 1'b0; settle();
    chk("x0_done_stall", 32'(s2_stall), 32'd0);
    chk("x0_done_ldwd", ld_wd, 32'hDEAD_BEEF);
    chk("x0_done_ldwe", 32'(ld_we), 32'd0);
    tick();

    // Signed half load lh 0x7002 of 0x87654321.
    mem_req = 1'b1; mem_size = 2'd1; mem_signed = 1'b1; mem_addr = 32'h0000_7002; rd_idx = 5'd3;
    dif.dcache_req_ready = 1'b1;
    tick(); mem_req = 1'b0;
    tick(); dif.dcache_req_ready = 1'b0; dif.dcache_rsp_valid = 1'b1; dif.dcache_rdata = 32'h8765_4321;
    tick(); dif.dcache_rsp_valid = 1'b0; settle();
    chk("lh_done_ldwd", ld_wd, 32'hFFFF_8765);
    chk("lh_done_ldwe", 32'(ld_we), 32'd1);
    tick();

    // Unsigned byte load lbu 0x8001 with flush and the response in the same WAIT cycle.
    mem_req = 1'b1; mem_size = 2'd0; mem_signed = 1'b0; mem_addr = 32'h0000_8001; rd_idx = 5'd4;
    dif.dcache_req_ready = 1'b1;
    tick(); mem_req = 1'b0;
    tick(); dif.dcache_req_ready = 1'b0; dif.dcache_rsp_valid = 1'b1; dif.dcache_rdata = 32'h0000_A500;
    flush = 1'b1;
    tick(); dif.dcache_rsp_valid = 1'b0; flush = 1'b0; settle();
    chk("flrsp_done_stall", 32'(s2_stall), 32'd0);
    chk("flrsp_done_ldwd", ld_wd, 32'h0000_00A5);
    chk("flrsp_done_ldwe", 32'(ld_we), 32'd0);
    tick();

    // Reset in WAIT abandons the access.
    mem_req = 1'b1; mem_size = 2'd2; mem_addr = 32'h0000_9000; rd_idx = 5'd8;
    dif.dcache_req_ready = 1'b1;
    tick(); mem_req = 1'b0;
    tick(); dif.dcache_req_ready = 1'b0; settle();
    chk("mr_wait_stall", 32'(s2_stall), 32'd1);
    rst_n = 1'b0; settle();
    chk("mr_rst_stall", 32'(s2_stall), 32'd0);
    chk("mr_rst_addr", dif.dcache_addr, 32'h0);
    dif.dcache_rsp_valid = 1'b1; dif.dcache_rdata = 32'h1234_5678;
    tick(); rst_n = 1'b1;
    tick(); dif.dcache_rsp_valid = 1'b0; settle();
    chk("mr_after_stall", 32'(s2_stall), 32'd0);
    chk("mr_after_ldwe", 32'(ld_we), 32'd0);
    chk("mr_after_buserr", 32'(bus_err), 32'd0);
    chk("mr_after_valid", 32'(dif.dcache_req_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/core_s2_lsu_seq.md
CORE_S2_LSU_SEQ -- requirements
Module: core_s2_lsu_seq

Interface
REQ-001 The block SHALL have parameter RSP_TIMEOUT, default 1023: maximum cycles spent waiting for a load response.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous reset, active low
- mem_req  in  1  stage-2 instruction is a load/store
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- mem_signed  in  1  sign-extend load result
- mem_addr  in  32  effective address (ALU result)
- mem_wd  in  32  store data (rs2)
- rd_idx  in  5  load destination register
- flush  in  1  kill current stage-2 instruction
- dcache_req_valid  out  1  request valid
- dcache_req_ready  in  1  dcache accepts request
- dcache_addr  out  32  request address
- dcache_we  out  1  write request
- dcache_wdata  out  32  lane-replicated store data
- dcache_wmask  out  4  byte-enable mask
- dcache_rsp_valid  in  1  load response valid
- dcache_rdata  in  32  load response word
- s2_stall  out  1  hold stage 2
- ld_we  out  1  register-file write enable for the load result
- ld_rd_idx  out  5  load write index
- ld_wd  out  32  load write data
- misaligned  out  1  misaligned or illegal-size access, 1-cycle pulse
- bus_err  out  1  response timeout, 1-cycle pulse

Function
REQ-003 The FSM SHALL have the states IDLE, REQ, WAIT, DONE.
REQ-004 An access SHALL be misaligned if mem_size=3, if mem_size=1 and addr[0]=1, or if mem_size=2 and addr[1:0]!=0.
REQ-005 In IDLE with mem_req=1 and a misaligned access, the block SHALL assert misaligned combinationally in that cycle, assert neither s2_stall nor dcache_req_valid, and remain in IDLE.
REQ-006 In IDLE with mem_req=1 and an aligned access, the block SHALL latch addr, we, size, signed, rd_idx, the wdata image and the wmask, assert s2_stall combinationally, and enter REQ.
REQ-007 In REQ, dcache_req_valid SHALL be 1 and all dcache_* request outputs SHALL hold stable, from registers, until dcache_req_ready=1.
REQ-008 On a REQ handshake, a store SHALL go to DONE and a load SHALL go to WAIT with the timeout counter cleared.
REQ-009 In WAIT, dcache_rsp_valid=1 SHALL capture dcache_rdata and go to DONE.
REQ-010 In WAIT, the counter SHALL increment each cycle; reaching RSP_TIMEOUT SHALL go to DONE with an error flag set.
REQ-011 s2_stall SHALL be 1 in REQ and WAIT, and 0 in DONE.
REQ-012 DONE SHALL last exactly one cycle and then return to IDLE; mem_req SHALL be ignored while in DONE.
REQ-013 In DONE for a load, ld_we SHALL be 1 only if the access is not killed, not in error, and ld_rd_idx!=0.
REQ-014 In DONE, bus_err SHALL pulse when the error flag is set.
REQ-015 The store mask SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
REQ-016 The store data SHALL be: byte {4{wd[7:0]}}; half {2{wd[15:0]}}; word wd.
REQ-017 The load data SHALL be rdata>>(8*addr[1:0]), truncated to the access size, then sign- or zero-extended to 32 bits per mem_signed.
REQ-018 flush in IDLE SHALL suppress a new request.
REQ-019 flush in REQ SHALL NOT retract dcache_req_valid; the handshake SHALL complete, the response SHALL still be consumed, and the access SHALL be marked killed.
REQ-020 flush in WAIT or DONE SHALL mark the access killed.
REQ-021 dcache_rsp_valid outside WAIT SHALL be ignored.
REQ-022 flush and dcache_rsp_valid in the same cycle in WAIT SHALL go to DONE killed, with ld_we=0.

Reset
REQ-023 While rst_n=0, the state SHALL be IDLE, all outputs SHALL be 0, and all latched fields, the counter and the flags SHALL be 0.
REQ-024 Reset mid-access SHALL abandon the access with no ld_we and no pulse output.

Verification
REQ-025 The bench SHALL cover a signed byte load: lb with addr=0x1003, ready in the same cycle, rsp 2 cycles later with rdata=0x80FFFFFF -> ld_wd=0xFFFFFF80 and ld_we=1 in DONE, with s2_stall high for 4 cycles.
REQ-026 The bench SHALL cover a half store: sh with addr=0x2002, wd=0x1234ABCD, ready held low for 3 cycles -> valid and outputs stable throughout, then wmask=1100 and wdata=0xABCDABCD.
REQ-027 The bench SHALL cover a misaligned access: lw with addr=0x3001 -> misaligned pulse for 1 cycle, no valid, no stall.
REQ-028 The bench SHALL cover a timeout: RSP_TIMEOUT=4 with no response -> bus_err pulse in DONE, ld_we=0.
REQ-029 The bench SHALL cover a flush during a load: flush asserted in REQ -> handshake completes, response consumed, ld_we=0.
REQ-030 The bench SHALL cover a write to x0: lw to rd_idx=0 -> DONE reached with ld_we=0.
